// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters and the rr_arbiter_4 scheduler.
// The master side drives requests; the slave side (arbiter) returns the grant.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (output req, input gnt, gnt_idx, gnt_valid);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and held ownership.
// Optional hold limit: define RR_ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles.

// Per-requester slice: eligibility for the current arbitration and next grant bit.
module rr_arb_lane #(
  parameter int unsigned IDX = 0
) (
  input  logic       req,
  input  logic [1:0] owner,
  input  logic       excl,
  input  logic       grant_d,
  input  logic [1:0] idx_d,
  output logic       elig,
  output logic       gnt_nxt
);
  assign elig    = req && !(excl && (owner == 2'(IDX)));
  assign gnt_nxt = grant_d && (idx_d == 2'(IDX));
endmodule

module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     hold_q, hold_d, hold_inc;
  logic           owner_req, tmo_hit, excl, found;
  logic [1:0]     winner;
  logic [NUM_LANES-1:0] elig, gnt_nxt;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_4: MAX_HOLD must be in 2..255");
  end

  assign owner_req = bus.req[idx_q];
  // The current owner is only excluded while it holds the grant.
  assign excl      = (state_q == GRANT);

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [3:0] owner_oh;
  logic       others;
  assign owner_oh = 4'b0001 << idx_q;
  assign others   = |(bus.req & ~owner_oh);
  assign tmo_hit  = (hold_q == HOLD_LAST) && others;
  assign hold_inc = (hold_q >= HOLD_LAST) ? HOLD_LAST : hold_q + 8'd1;
`else
  assign tmo_hit  = 1'b0;
  assign hold_inc = (hold_q == 8'hFF) ? 8'hFF : hold_q + 8'd1;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rr_arb_lane #(.IDX(i)) u_lane (
      .req     (bus.req[i]),
      .owner   (idx_q),
      .excl    (excl),
      .grant_d (state_d == GRANT),
      .idx_d   (idx_d),
      .elig    (elig[i]),
      .gnt_nxt (gnt_nxt[i])
    );
  end

  // First eligible requester in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    logic [1:0] cand;
    found  = 1'b0;
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        idx_d = 2'd0;
        if (found) begin
          state_d = GRANT;
          idx_d   = winner;
          ptr_d   = winner + 2'd1;
          hold_d  = 8'd0;
        end
      end
      GRANT: begin
        if (owner_req && !tmo_hit) begin
          hold_d = hold_inc;
        end else if (found) begin
          idx_d  = winner;
          ptr_d  = winner + 2'd1;
          hold_d = 8'd0;
        end else begin
          state_d = IDLE;
          idx_d   = 2'd0;
          hold_d  = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 2'd0;
      idx_q         <= 2'd0;
      hold_q        <= 8'd0;
      bus.gnt       <= 4'b0000;
      bus.gnt_idx   <= 2'd0;
      bus.gnt_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      bus.gnt       <= gnt_nxt;
      bus.gnt_idx   <= idx_d;
      bus.gnt_valid <= (state_d == GRANT);
    end
  end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: integer-level round-robin model checked every
// cycle, plus literal grant expectations along the stimulus script.
module tb_rr_arbiter_4;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_arbiter_4_if bus();

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: owner is -1 when idle; ptr/hold are plain integers.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic int pick(logic [3:0] r, int p, int excl_id);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (r[c] && c != excl_id) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] r;
    int  w;
    int  cap;
    bit  tmo;
    r   = bus.req;
    tmo = 1'b0;
    cap = 255;
`ifdef RR_ARB_TIMEOUT_EN
    cap = MH - 1;
`endif
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_ptr, -1);
      if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 4; m_hold = 0; end
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      tmo = (m_hold == MH - 1) && (pick(r, m_ptr, m_owner) >= 0);
`endif
      if (r[m_owner] && !tmo) begin
        m_hold = (m_hold + 1 > cap) ? cap : m_hold + 1;
      end else begin
        w = pick(r, m_ptr, m_owner);
        if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 4; m_hold = 0; end
        else begin m_owner = -1; m_hold = 0; end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    logic [3:0] eg;
    logic [1:0] ei;
    #1;
    eg = 4'b0000;
    ei = 2'd0;
    if (m_owner >= 0) begin
      eg = 4'b0001 << m_owner;
      ei = 2'(m_owner);
    end
    chk("model_gnt", 8'(bus.gnt), 8'(eg));
    chk("model_idx", 8'(bus.gnt_idx), 8'(ei));
    chk("model_valid", 8'(bus.gnt_valid), 8'(m_owner >= 0));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.req = 4'b1111;
    // Reset held two cycles with all requests up
    step(); step();
    chk("rst_gnt", 8'(bus.gnt), 8'h0);
    chk("rst_idx", 8'(bus.gnt_idx), 8'h0);
    chk("rst_valid", 8'(bus.gnt_valid), 8'h0);
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", 8'(bus.gnt), 8'h1);
    chk("post_rst_idx", 8'(bus.gnt_idx), 8'h0);

    // Round robin: each owner holds two cycles then drops for one
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_hold", 8'(bus.gnt), 8'(4'b0001 << k));
      bus.req = 4'b1111 & ~(4'b0001 << k);
      step();
      chk("rr_next", 8'(bus.gnt), 8'(4'b0001 << ((k + 1) % 4)));
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;
    step();
    chk("rr_idle", 8'(bus.gnt_valid), 8'h0);

    // Single requester
    bus.req = 4'b0100;
    step();
    chk("single_gnt", 8'(bus.gnt), 8'h4);
    chk("single_idx", 8'(bus.gnt_idx), 8'h2);
    bus.req = 4'b0000;
    step();
    chk("single_drop", 8'(bus.gnt), 8'h0);
    chk("single_valid", 8'(bus.gnt_valid), 8'h0);

    // Wrap: grant 2 leaves ptr=3, then 1001 picks 3, release picks 0
    bus.req = 4'b0100;
    step();
    chk("wrap_g2", 8'(bus.gnt), 8'h4);
    bus.req = 4'b1001;
    step();
    chk("wrap_g3", 8'(bus.gnt), 8'h8);
    bus.req = 4'b0001;
    step();
    chk("wrap_g0", 8'(bus.gnt), 8'h1);
    bus.req = 4'b0000;
    step();

    // Priority: ptr=2 with 1011 -> winner 3
    bus.req = 4'b0010;
    step();
    chk("prio_g1", 8'(bus.gnt), 8'h2);
    bus.req = 4'b0000;
    step();
    bus.req = 4'b1011;
    step();
    chk("prio_g3", 8'(bus.gnt), 8'h8);
    chk("prio_idx", 8'(bus.gnt_idx), 8'h3);
    bus.req = 4'b0000;
    step();

    // Reset mid-grant (ptr=0 here)
    bus.req = 4'b0010;
    step();
    chk("mid_g1", 8'(bus.gnt), 8'h2);
    step();
    chk("mid_hold", 8'(bus.gnt), 8'h2);
    rst_n = 1'b0;
    step();
    chk("mid_rst_gnt", 8'(bus.gnt), 8'h0);
    chk("mid_rst_valid", 8'(bus.gnt_valid), 8'h0);
    rst_n = 1'b1;
    bus.req = 4'b0011;
    step();
    chk("mid_after", 8'(bus.gnt), 8'h1);

    // Owner 0 keeps requesting while requester 1 waits
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 2; c <= MH; c++) begin
      step();
      chk("tmo_hold", 8'(bus.gnt), 8'h1);
    end
    step();
    chk("tmo_rotate", 8'(bus.gnt), 8'h2);
`else
    for (int c = 0; c < 12; c++) begin
      step();
      chk("notmo_hold", 8'(bus.gnt), 8'h1);
    end
`endif
    bus.req = 4'b0000;
    step();
    chk("end_idle", 8'(bus.gnt), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
